ram_dp_clr: RTL and testbench

//  Parametrised true-dual-port synchronous RAM for the SAP-2 datapath. Port A serves the CPU bus; port B serves loader/debug/DMA.

---
 rtl/arch_defs_pkg.sv | 16 +
 rtl/ram_clear_seq.sv | 64 ++++++
 rtl/ram_dp_clr.sv | 138 +++++++++++++
 tb/tb_ram_dp_clr.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/arch_defs_pkg.sv
// Shared type definitions for the SAP-2 memory datapath.
package arch_defs_pkg;

  // Read-during-write result: old word or newly written word.
  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  // Clear sequencer state.
  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_BUSY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks addresses 0..DEPTH-1 emitting one fill write per
// cycle, either after reset release or on a single-cycle request.
module ram_clear_seq
  import arch_defs_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DEPTH          = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_req_i,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next-state: requests in IDLE start a sweep; the sweep ends after the last word.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      CLR_IDLE: begin
        if (clear_req_i) begin
          state_d = CLR_BUSY;
          addr_d  = '0;
        end
      end
      CLR_BUSY: begin
        if (addr_q == LAST_ADDR) begin
          state_d = CLR_IDLE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: begin
        state_d = CLR_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // State register; reset restarts any sweep from address 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CLEAR_ON_RESET ? CLR_BUSY : CLR_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign busy_o     = (state_q == CLR_BUSY);
  assign clr_we_o   = (state_q == CLR_BUSY);
  assign clr_addr_o = addr_q;

endmodule

// File: rtl/ram_dp_clr.sv
// True-dual-port synchronous RAM with selectable read-during-write behaviour,
// port-A-wins write arbitration and a hardware clear sequencer.
module ram_dp_clr
  import arch_defs_pkg::*;
#(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 4,
  parameter int                DEPTH          = 16,
  parameter rdw_mode_e         RDW_MODE       = RDW_READ_FIRST,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  parameter                    INIT_FILE      = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clear_req,
  output logic              busy,
  output logic              collision
);

  if ((DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : g_depth_chk
    $error("ram_dp_clr: DEPTH must be in 1..2**ADDR_W");
  end

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clear_seq #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_req_i (clear_req),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr),
    .busy_o      (busy)
  );

  logic              a_in, b_in, same_addr;
  logic              a_wr, b_wr_req, b_wr, coll_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              collision_q;

  // Access decode, write arbitration and read-data selection.
  always_comb begin
    a_in      = ({1'b0, a_addr} < DEPTH_W);
    b_in      = ({1'b0, b_addr} < DEPTH_W);
    same_addr = (a_addr == b_addr);
    a_wr      = a_en && a_we && a_in && !busy;
    b_wr_req  = b_en && b_we && b_in && !busy;
    // Port A owns the word when both ports write the same address.
    coll_d    = a_wr && b_wr_req && same_addr;
    b_wr      = b_wr_req && !coll_d;

    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    if (busy) begin
      a_rdata_d = '0;
      b_rdata_d = '0;
    end else begin
      if (a_en) begin
        if (!a_in) begin
          a_rdata_d = '0;
        end else if (RDW_MODE == RDW_WRITE_FIRST && a_wr) begin
          a_rdata_d = a_wdata;
        end else if (RDW_MODE == RDW_WRITE_FIRST && b_wr && same_addr) begin
          a_rdata_d = b_wdata;
        end else begin
          a_rdata_d = mem[a_addr];
        end
      end
      if (b_en) begin
        if (!b_in) begin
          b_rdata_d = '0;
        end else if (RDW_MODE == RDW_WRITE_FIRST && a_wr && same_addr) begin
          b_rdata_d = a_wdata;
        end else if (RDW_MODE == RDW_WRITE_FIRST && b_wr) begin
          b_rdata_d = b_wdata;
        end else begin
          b_rdata_d = mem[b_addr];
        end
      end
    end
  end

  // Memory array writes and registered outputs; reset touches only the outputs.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (clr_we) begin
        mem[clr_addr] <= CLEAR_VALUE;
      end else begin
        if (a_wr) mem[a_addr] <= a_wdata;
        if (b_wr) mem[b_addr] <= b_wdata;
      end
    end
    if (!reset_n) begin
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      collision_q <= coll_d;
    end
  end

  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign collision = collision_q;

`ifndef SYNTHESIS
  // Debug helper: prints the implemented words.
  task automatic dump();
    for (int i = 0; i < DEPTH; i++) begin
      $write("mem[%0d] = %h\n", i, mem[i]);
    end
  endtask
`endif

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench: two instances share stimulus. u_rf is READ_FIRST with
// DEPTH=16; u_wf is WRITE_FIRST with DEPTH=12 (addresses 12..15 unimplemented).
module tb_ram_dp_clr;
  import arch_defs_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0, clear_req = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;

  logic [7:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
  logic       busy0, coll0, busy1, coll1;

  int tests = 0;
  int fails = 0;
  int cnt0, cnt1;
  logic [7:0] exp0 [16];
  logic [7:0] exp1 [16];

  always #5 clk = ~clk;

  ram_dp_clr #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(16), .RDW_MODE(RDW_READ_FIRST),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00), .INIT_FILE("")
  ) u_rf (
    .clk(clk), .reset_n(reset_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata0),
    .clear_req(clear_req), .busy(busy0), .collision(coll0)
  );

  ram_dp_clr #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(12), .RDW_MODE(RDW_WRITE_FIRST),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00), .INIT_FILE("")
  ) u_wf (
    .clk(clk), .reset_n(reset_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata1),
    .clear_req(clear_req), .busy(busy1), .collision(coll1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    clear_req = 1'b0;
  endtask

  initial begin
    // Reset with automatic clear
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_busy0", busy0, 1);
    check("rst_busy1", busy1, 1);
    check("rst_a_rdata0", a_rdata0, 8'h00);
    check("rst_b_rdata1", b_rdata1, 8'h00);
    check("rst_coll0", coll0, 0);

    reset_n = 1'b1;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 20; i++) begin
      cnt0 += int'(busy0);
      cnt1 += int'(busy1);
      if (i == 8) check("busy_a_rdata0", a_rdata0, 8'h00);
      if (i < 4) begin
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'hEE;
      end else begin
        idle();
      end
      tick();
    end
    check("clr_len0", cnt0, 16);
    check("clr_len1", cnt1, 12);

    for (int i = 0; i < 16; i++) begin
      a_en = 1'b1; a_we = 1'b0; a_addr = 4'(i);
      tick();
      check($sformatf("clr_rd0_%0d", i), a_rdata0, 8'h00);
      check($sformatf("clr_rd1_%0d", i), a_rdata1, 8'h00);
    end
    idle();

    // Write then read on port A, hold when disabled
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_wdata = 8'hA5;
    tick();
    check("wr5_rdw0", a_rdata0, 8'h00);
    check("wr5_rdw1", a_rdata1, 8'hA5);
    a_we = 1'b0;
    tick();
    check("rd5_0", a_rdata0, 8'hA5);
    check("rd5_1", a_rdata1, 8'hA5);
    a_en = 1'b0;
    tick();
    check("hold5_0", a_rdata0, 8'hA5);
    check("hold5_1", a_rdata1, 8'hA5);

    // Read-during-write, cross port and same port
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 8'h11;
    tick();
    a_wdata = 8'h22;
    b_en = 1'b1; b_we = 1'b0; b_addr = 4'd7;
    tick();
    check("rdw_b0", b_rdata0, 8'h11);
    check("rdw_b1", b_rdata1, 8'h22);
    check("rdw_a0", a_rdata0, 8'h11);
    check("rdw_a1", a_rdata1, 8'h22);
    idle();

    // Write-write collision
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd9; a_wdata = 8'h33;
    b_en = 1'b1; b_we = 1'b1; b_addr = 4'd9; b_wdata = 8'h44;
    tick();
    check("coll0", coll0, 1);
    check("coll1", coll1, 1);
    check("coll_a0", a_rdata0, 8'h00);
    check("coll_a1", a_rdata1, 8'h33);
    check("coll_b0", b_rdata0, 8'h00);
    check("coll_b1", b_rdata1, 8'h33);
    idle();
    tick();
    check("coll_clr0", coll0, 0);
    check("coll_clr1", coll1, 0);
    a_en = 1'b1; a_addr = 4'd9;
    tick();
    check("coll_rd0", a_rdata0, 8'h33);
    check("coll_rd1", a_rdata1, 8'h33);
    idle();

    // Out-of-range address (only beyond DEPTH on u_wf)
    b_en = 1'b1; b_we = 1'b1; b_addr = 4'd14; b_wdata = 8'h55;
    tick();
    check("oor_wr_b0", b_rdata0, 8'h00);
    check("oor_wr_b1", b_rdata1, 8'h00);
    check("oor_coll1", coll1, 0);
    b_we = 1'b0;
    tick();
    check("oor_rd_b0", b_rdata0, 8'h55);
    check("oor_rd_b1", b_rdata1, 8'h00);
    idle();

    for (int i = 0; i < 16; i++) begin
      exp0[i] = 8'h00;
      exp1[i] = 8'h00;
    end
    exp0[5] = 8'hA5; exp0[7] = 8'h22; exp0[9] = 8'h33; exp0[14] = 8'h55;
    exp1[5] = 8'hA5; exp1[7] = 8'h22; exp1[9] = 8'h33;
    for (int i = 0; i < 16; i++) begin
      a_en = 1'b1; a_addr = 4'(i);
      tick();
      check($sformatf("img0_%0d", i), a_rdata0, exp0[i]);
      check($sformatf("img1_%0d", i), a_rdata1, exp1[i]);
    end
    idle();

    // Requested clear interrupted by reset at clr_addr=6
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("req_busy0", busy0, 1);
    check("req_a_rdata0", a_rdata0, 8'h00);
    for (int i = 0; i < 6; i++) tick();
    check("mid_busy1", busy1, 1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_busy0", busy0, 1);
    check("mid_rst_busy1", busy1, 1);
    reset_n = 1'b1;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 20; i++) begin
      cnt0 += int'(busy0);
      cnt1 += int'(busy1);
      clear_req = (i == 5);
      tick();
    end
    clear_req = 1'b0;
    check("reclr_len0", cnt0, 16);
    check("reclr_len1", cnt1, 12);
    a_en = 1'b1; a_addr = 4'd5;
    tick();
    check("reclr_rd5_0", a_rdata0, 8'h00);
    check("reclr_rd5_1", a_rdata1, 8'h00);
    a_addr = 4'd14;
    tick();
    check("reclr_rd14_0", a_rdata0, 8'h00);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
